mulalu: RTL

MULALU -- requirements
Module: mulalu

---
 rtl/mulalu_pkg.sv | 28 ++
 rtl/mulalu_divcore.sv | 45 ++++
 rtl/mulalu.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mulalu_pkg.sv
// mulalu shared datapath package.
// Opcode macros, FSM states and iteration count.
`ifndef MULALU_DEFINES_VH
`define MULALU_DEFINES_VH
`define FUNC_MUL 5'b00001
`define FUNC_DIV 5'b00010
`endif

package mulalu_pkg;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a 32-bit operand, two's complement when signed.
    function automatic logic [31:0] mag32(
        input logic [31:0] x,
        input logic        sgn
    );
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mulalu_divcore.sv
// mulalu restoring divider core.
// One quotient bit per step on unsigned magnitudes.
module mulalu_divcore (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // Restore on borrow, otherwise keep difference and shift in a 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= diff[32] ? shifted[31:0] : diff[31:0];
            quo_q <= {quo_q[30:0], ~diff[32]};
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/mulalu.sv
// mulalu iterative multiply/divide unit.
// 32 radix-2 steps, fixed latency, HI/LO write strobes.
module mulalu
    import mulalu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  mulalu_func,
    input  logic        mulalu_sign,
    input  logic [31:0] source_a,
    input  logic [31:0] source_b,
    input  logic        flush,
    output logic        stall,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_write_data,
    output logic [31:0] lo_write_data
);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      prod_q;
    logic [31:0]      mcand_q;
    logic [31:0]      a_raw_q;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_rem_q;
    logic             bzero_q;

    logic        req;
    logic        load;
    logic        step;
    logic        stall_c;
    logic        done_c;
    logic        sa;
    logic        sb;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] sum;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [63:0] res;

    assign req   = |mulalu_func;
    assign sa    = mulalu_sign & source_a[31];
    assign sb    = mulalu_sign & source_b[31];
    assign a_mag = mag32(source_a, mulalu_sign);
    assign b_mag = mag32(source_b, mulalu_sign);

    // Next state and handshake; flush wins in every state.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        stall_c = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !flush) begin
                    load    = 1'b1;
                    stall_c = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step    = 1'b1;
                    stall_c = 1'b1;
                    if (cnt_q == CNT_W'(MULDIV_ITER - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_c  = ~flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter, cleared on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Operand latch and sign bookkeeping at accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand_q   <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else if (load) begin
            mcand_q   <= a_mag;
            a_raw_q   <= source_a;
            is_div_q  <= (mulalu_func == `FUNC_DIV);
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            bzero_q   <= (source_b == 32'd0);
        end
    end

    // Shift-add multiply: conditionally add multiplicand, shift right.
    always_comb begin
        sum = {1'b0, prod_q[63:32]}
            + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    end

    // Product accumulator; low half starts as the multiplier.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_q <= '0;
        end else if (load) begin
            prod_q <= {32'd0, b_mag};
        end else if (step && !is_div_q) begin
            prod_q <= {sum, prod_q[31:1]};
        end
    end

    mulalu_divcore u_divcore (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .step     (step & is_div_q),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (quo),
        .rem      (rem)
    );

    // Sign fix-up and divide-by-zero result selection.
    always_comb begin
        prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;
        q_fix    = neg_q ? (~quo + 32'd1) : quo;
        r_fix    = neg_rem_q ? (~rem + 32'd1) : rem;
        if (!is_div_q) begin
            res = prod_fix;
        end else if (bzero_q) begin
            res = {a_raw_q, 32'hFFFF_FFFF};
        end else begin
            res = {r_fix, q_fix};
        end
    end

    assign stall         = resetn & stall_c;
    assign hi_write      = done_c;
    assign lo_write      = done_c;
    assign hi_write_data = done_c ? res[63:32] : 32'd0;
    assign lo_write_data = done_c ? res[31:0] : 32'd0;

endmodule
